// File: rtl/gray_code_counter.sv
// Registered up/down binary counter with a registered Gray-code view and a
// one-cycle wrap pulse; supports synchronous load of binary or Gray values.
module gray_code_counter #(
    parameter int unsigned           WIDTH    = 4,
    parameter logic [WIDTH-1:0]      INIT_BIN = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_next;
    logic             wrap_next;

    // Gray to binary: running XOR from the MSB down.
    always_comb begin
        load_bin = load_val;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ load_val[i];
        end
    end

    // Wrap is decided from the pre-step value, so no carry bit is kept.
    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_is_gray ? load_bin : load_val;
        end else if (en) begin
            if (up_dn) begin
                bin_next  = bin_q + WIDTH'(1);
                wrap_next = (bin_q == {WIDTH{1'b1}});
            end else begin
                bin_next  = bin_q - WIDTH'(1);
                wrap_next = (bin_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= bin_next ^ (bin_next >> 1);
            wrap_q <= wrap_next;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: 4-bit (INIT 0 and 7) and 8-bit instances
// share control inputs; expected values are hand-derived constants.
module tb_gray_code_counter;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, load, load_is_gray;
    logic [3:0] lv4;
    logic [7:0] lv8;
    logic [3:0] bin0, gray0, bin7, gray7;
    logic [7:0] bin8, gray8;
    logic       wrap0, wrap7, wrap8;

    int total = 0;
    int bad   = 0;

    int gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(4), .INIT_BIN(4'd0)) u_c0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_is_gray(load_is_gray), .load_val(lv4),
        .bin_out(bin0), .gray_out(gray0), .wrap(wrap0)
    );

    gray_code_counter #(.WIDTH(4), .INIT_BIN(4'd7)) u_c7 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_is_gray(load_is_gray), .load_val(lv4),
        .bin_out(bin7), .gray_out(gray7), .wrap(wrap7)
    );

    gray_code_counter #(.WIDTH(8), .INIT_BIN(8'd0)) u_c8 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_is_gray(load_is_gray), .load_val(lv8),
        .bin_out(bin8), .gray_out(gray8), .wrap(wrap8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input int b, input int g, input int w);
        chk({tag, ".bin"},  32'(bin0),  32'(b));
        chk({tag, ".gray"}, 32'(gray0), 32'(g));
        chk({tag, ".wrap"}, 32'(wrap0), 32'(w));
    endtask

    // Independent Gray decode: b = g ^ g>>1 ^ g>>2 ^ ...
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int s = 1; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    logic [3:0] prev_gray;

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_is_gray = 1'b0;
        lv4 = '0; lv8 = '0;
        tick();
        chk4("reset0", 0, 0, 0);
        chk("reset7.bin",  32'(bin7),  32'd7);
        chk("reset7.gray", 32'(gray7), 32'd4);
        chk("reset7.wrap", 32'(wrap7), 32'd0);
        chk("reset8.bin",  32'(bin8),  32'd0);

        // Full up-count through wrap
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        prev_gray = gray0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk4($sformatf("up%0d", k), k % 16, gtab[k % 16], (k == 16) ? 1 : 0);
            chk($sformatf("onebit%0d", k), 32'($countones(prev_gray ^ gray0)), 32'd1);
            prev_gray = gray0;
        end

        // Down through zero
        up_dn = 1'b0;
        tick(); chk4("dn_to0", 0, 0, 0);
        tick(); chk4("dn_wrap", 15, 8, 1);
        tick(); chk4("dn_14", 14, 9, 0);

        // Loads
        en = 1'b0; load = 1'b1; load_is_gray = 1'b1; lv4 = 4'b1101;
        tick(); chk4("ld_gray", 9, 13, 0);
        load_is_gray = 1'b0; lv4 = 4'b0101;
        tick(); chk4("ld_bin", 5, 7, 0);
        lv4 = 4'd15;
        tick(); chk4("ld_15", 15, 8, 0);
        en = 1'b1; up_dn = 1'b1;
        tick(); chk4("ld_over_en", 15, 8, 0);

        // Reset overrides count and load
        load = 1'b0; rst = 1'b1;
        tick();
        chk4("rst_mid", 0, 0, 0);
        chk("rst_mid7.bin",  32'(bin7),  32'd7);
        chk("rst_mid7.gray", 32'(gray7), 32'd4);
        chk("rst_mid7.wrap", 32'(wrap7), 32'd0);
        load = 1'b1; lv4 = 4'd9;
        tick(); chk4("rst_over_ld", 0, 0, 0);
        rst = 1'b0; en = 1'b1;
        tick(); chk4("after_rst_ld", 9, 13, 0);

        // Hold
        load = 1'b0; lv4 = 4'd3; load = 1'b1;
        tick(); chk4("ld_3", 3, 2, 0);
        load = 1'b0; up_dn = 1'b1;
        tick(); chk4("up_4", 4, 6, 0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); chk4($sformatf("hold%0d", k), 4, 6, 0);
        end

        // Direction toggles every cycle
        load = 1'b1;
        tick(); chk4("ld_3b", 3, 2, 0);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up_dn = (k % 2 == 0);
            tick();
            chk4($sformatf("tog%0d", k), (k % 2 == 0) ? 4 : 3, (k % 2 == 0) ? 6 : 2, 0);
        end

        // Back-to-back wraps
        load = 1'b1; lv4 = 4'd0;
        tick(); chk4("ld_0", 0, 0, 0);
        load = 1'b0; up_dn = 1'b0;
        tick(); chk4("bb_wrap_dn", 15, 8, 1);
        up_dn = 1'b1;
        tick(); chk4("bb_wrap_up", 0, 0, 1);

        // 8-bit: Gray 0x80 decodes to 0xFF, then wraps up
        en = 1'b0; load = 1'b1; load_is_gray = 1'b1; lv8 = 8'h80;
        tick();
        chk("w8_ld.bin",  32'(bin8),  32'hFF);
        chk("w8_ld.gray", 32'(gray8), 32'h80);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("w8_up.bin",  32'(bin8),  32'h00);
        chk("w8_up.gray", 32'(gray8), 32'h00);
        chk("w8_up.wrap", 32'(wrap8), 32'd1);

        // Every Gray load round-trips
        load = 1'b1;
        for (int g = 0; g < 256; g++) begin
            lv8 = 8'(g);
            tick();
            chk($sformatf("rt%0d.bin", g),  32'(bin8),  32'(g2b(8'(g))));
            chk($sformatf("rt%0d.gray", g), 32'(gray8), 32'(g));
        end
        chk("rt_wrap", 32'(wrap8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
